// File: rtl/button_event_decoder_if.sv
// Button-event bundle: debounced level in, registered level and single-cycle event pulses out.
// The release pulse is named release_edge because "release" is a reserved word in SystemVerilog.
interface button_event_decoder_if;
  logic level;
  logic pressed;
  logic press;
  logic release_edge;
  logic click;
  logic double_click;
  logic long_press;

  modport master (
    output level,
    input  pressed, press, release_edge, click, double_click, long_press
  );

  modport slave (
    input  level,
    output pressed, press, release_edge, click, double_click, long_press
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns one debounced button level into registered single-cycle press/release/click/
// double_click/long_press pulses using a five-state FSM and one shared cycle counter.
module button_event_decoder #(
  parameter int FREQ      = 27_000_000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.slave  btn
);

  localparam int LONG_CYC = FREQ / 1000 * LONG_MS;
  localparam int GAP_CYC  = FREQ / 1000 * DOUBLE_MS;
  localparam int MAX_CYC  = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int CW       = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DOWN1 = 3'd1;
  localparam logic [2:0] WAIT2 = 3'd2;
  localparam logic [2:0] DOWN2 = 3'd3;
  localparam logic [2:0] LONG  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          prev;
  logic          rise, fall;
  logic          press_d, release_d, click_d, double_d, long_d;

  assign rise = btn.level & ~prev;
  assign fall = ~btn.level & prev;

  // Edges are tested before timeouts so an edge wins when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = DOWN1;
          press_d   = 1'b1;
        end
      end
      DOWN1: begin
        if (fall) begin
          state_nxt = WAIT2;
          release_d = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          long_d    = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_nxt = DOWN2;
          press_d   = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          click_d   = 1'b1;
        end
      end
      DOWN2: begin
        if (fall) begin
          state_nxt = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (cnt == LONG_LAST) begin
          // The first tap of an abandoned double click is still reported as a click.
          state_nxt = LONG;
          long_d    = 1'b1;
          click_d   = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_nxt = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state)
      cnt_nxt = '0;
    else if (state == DOWN1 || state == WAIT2 || state == DOWN2)
      cnt_nxt = cnt + CW'(1);
  end

  // prev resets high so a button held through reset does not look like a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      prev             <= 1'b1;
      btn.pressed      <= 1'b0;
      btn.press        <= 1'b0;
      btn.release_edge <= 1'b0;
      btn.click        <= 1'b0;
      btn.double_click <= 1'b0;
      btn.long_press   <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      prev             <= btn.level;
      btn.pressed      <= btn.level;
      btn.press        <= press_d;
      btn.release_edge <= release_d;
      btn.click        <= click_d;
      btn.double_click <= double_d;
      btn.long_press   <= long_d;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder at 1 cycle/ms: LONG_CYC=20, GAP_CYC=8.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .FREQ      (1000),
    .LONG_MS   (20),
    .DOUBLE_MS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int n_press, n_rel, n_click, n_dbl, n_long;
  int t_press, t_rel, t_click, t_dbl, t_long;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0;
    t_press = -1; t_rel = -1; t_click = -1; t_dbl = -1; t_long = -1;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_no++;
    if (bus.press        === 1'b1) begin n_press++; t_press = cyc_no; end
    if (bus.release_edge === 1'b1) begin n_rel++;   t_rel   = cyc_no; end
    if (bus.click        === 1'b1) begin n_click++; t_click = cyc_no; end
    if (bus.double_click === 1'b1) begin n_dbl++;   t_dbl   = cyc_no; end
    if (bus.long_press   === 1'b1) begin n_long++;  t_long  = cyc_no; end
  endtask

  task automatic hold(input logic lvl, input int n);
    bus.level = lvl;
    repeat (n) cyc();
  endtask

  int t_rel_first;

  initial begin
    clr();
    bus.level = 1'b1;
    rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_pressed", int'(bus.pressed), 0);
    check("rst_press",   int'(bus.press), 0);
    check("rst_release", int'(bus.release_edge), 0);
    check("rst_click",   int'(bus.click), 0);
    check("rst_double",  int'(bus.double_click), 0);
    check("rst_long",    int'(bus.long_press), 0);

    // Button held through reset, then dropped
    clr();
    rst_n = 1'b1;
    hold(1'b1, 30);
    check("t1_pressed_hi", int'(bus.pressed), 1);
    check("t1_no_press",   n_press, 0);
    check("t1_no_long",    n_long, 0);
    hold(1'b0, 3);
    check("t1_pressed_lo", int'(bus.pressed), 0);
    check("t1_no_release", n_rel, 0);
    hold(1'b0, 10);
    check("t1_no_click",   n_click, 0);

    // Single click
    clr();
    hold(1'b1, 5);
    hold(1'b0, 12);
    check("t2_press",      n_press, 1);
    check("t2_release",    n_rel, 1);
    check("t2_click",      n_click, 1);
    check("t2_click_lat",  t_click - t_rel, 8);
    check("t2_no_double",  n_dbl, 0);

    // Double click: tap 5, gap 3, tap 4
    clr();
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 4);
    hold(1'b0, 12);
    check("t3_press",      n_press, 2);
    check("t3_release",    n_rel, 2);
    check("t3_double",     n_dbl, 1);
    check("t3_double_at",  t_dbl - t_rel, 0);
    check("t3_no_click",   n_click, 0);

    // Long press
    clr();
    hold(1'b1, 25);
    check("t4_long",       n_long, 1);
    check("t4_long_lat",   t_long - t_press, 20);
    hold(1'b0, 12);
    check("t4_release",    n_rel, 1);
    check("t4_no_click",   n_click, 0);
    check("t4_no_double",  n_dbl, 0);

    // Rise exactly on the last gap cycle still counts as a double click
    clr();
    hold(1'b1, 5);
    hold(1'b0, 8);
    hold(1'b1, 3);
    hold(1'b0, 12);
    check("t5_gap8_double",  n_dbl, 1);
    check("t5_gap8_noclick", n_click, 0);

    // One cycle longer gap resolves as click, then a fresh single click
    clr();
    hold(1'b1, 5);
    hold(1'b0, 1);
    t_rel_first = t_rel;
    hold(1'b0, 8);
    hold(1'b1, 3);
    hold(1'b0, 12);
    check("t5_gap9_nodouble", n_dbl, 0);
    check("t5_gap9_clicks",   n_click, 2);
    check("t5_gap9_press",    n_press, 2);

    clr();
    hold(1'b1, 5);
    hold(1'b0, 9);
    check("t5_gap9_first_lat", t_click - t_rel, 8);
    hold(1'b0, 5);
    t_rel_first = -1;

    // Fall on the last DOWN1 cycle beats long_press
    clr();
    hold(1'b1, 20);
    hold(1'b0, 12);
    check("t5_fall19_nolong",  n_long, 0);
    check("t5_fall19_release", n_rel, 1);
    check("t5_fall19_click",   n_click, 1);

    clr();
    hold(1'b1, 21);
    check("t5_hold21_long",    n_long, 1);
    check("t5_hold21_lat",     t_long - t_press, 20);
    hold(1'b0, 12);

    // Second tap held long: long_press and click together
    clr();
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 25);
    check("dl_long",        n_long, 1);
    check("dl_click",       n_click, 1);
    check("dl_click_at",    t_click - t_long, 0);
    check("dl_long_lat",    t_long - t_press, 20);
    hold(1'b0, 12);
    check("dl_no_double",   n_dbl, 0);
    check("dl_release",     n_rel, 2);

    // Reset during WAIT2 drops the pending click
    clr();
    hold(1'b1, 5);
    hold(1'b0, 3);
    rst_n = 1'b0;
    cyc();
    check("t6_rst_outs", int'({bus.pressed, bus.press, bus.release_edge,
                               bus.click, bus.double_click, bus.long_press}), 0);
    rst_n = 1'b1;
    hold(1'b0, 15);
    check("t6_no_click",    n_click, 0);
    check("t6_no_release2", n_rel, 1);

    clr();
    hold(1'b1, 5);
    hold(1'b0, 12);
    check("t6_press",      n_press, 1);
    check("t6_release",    n_rel, 1);
    check("t6_click",      n_click, 1);
    check("t6_click_lat",  t_click - t_rel, 8);
    check("t6_no_double",  n_dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
